axi_lite_slave_mem: RTL and testbench

- Synthesizable AXI4-Lite slave memory that terminates the slave side of `fake_axi`.
- Consumes its write-address, write-data and read-address channels and produces the write-response and read-data/response channels, with full valid/ready handshakes.
- Replaces the `AXI2_slave` DPI-C model as the default downstream endpoint, so master-side DPI traffic can run against real RTL.

---
 rtl/dpi_config.sv | 17 +
 rtl/axil_mem_array.sv | 38 +++
 rtl/axi_lite_slave_mem.sv | 160 ++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_config.sv
// Shared AXI4-Lite response codes, bus widths and FSM state types for the fake_axi endpoints.
package dpi_config;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_type;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_mem_array.sv
// DEPTH x 32 word storage: one byte-strobed write port, one asynchronous write-first read port.
// Contents are intentionally not reset.
module axil_mem_array
  import dpi_config::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [AXIL_DATA_W-1:0] i_wdata,
  input  logic [AXIL_STRB_W-1:0] i_wstrb,
  input  logic [AW-1:0]          i_raddr,
  output logic [AXIL_DATA_W-1:0] o_rdata
);

  logic [AXIL_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < AXIL_STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Bypass so a read sampled on the commit edge sees the bytes being written.
  always_comb begin
    o_rdata = r_mem[i_raddr];
    if (i_we && (i_waddr == i_raddr)) begin
      for (int b = 0; b < AXIL_STRB_W; b++) begin
        if (i_wstrb[b]) o_rdata[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave memory terminating fake_axi: independent write and read FSMs, DECERR outside the window.
// All outputs come straight from registers; responses are held until their ready handshake.
module axi_lite_slave_mem
  import dpi_config::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            s_wr_addr,
  input  logic                   s_wr_addr_valid,
  output logic                   s_wr_addr_ready,
  input  logic [AXIL_DATA_W-1:0] s_wr_data,
  input  logic [AXIL_STRB_W-1:0] s_wr_strb,
  input  logic                   s_wr_data_valid,
  output logic                   s_wr_data_ready,
  output resp_type               s_wr_resp,
  output logic                   s_wr_resp_valid,
  input  logic                   s_wr_resp_ready,
  input  logic [31:0]            s_rd_addr,
  input  logic                   s_rd_addr_valid,
  output logic                   s_rd_addr_ready,
  output logic [AXIL_DATA_W-1:0] s_rd_data,
  output resp_type               s_rd_resp,
  output logic                   s_rd_valid,
  input  logic                   s_rd_ready
);

  localparam int AW = $clog2(DEPTH);

  wr_state_t              r_wr_state;
  logic                   r_aw_rdy, r_w_rdy, r_b_vld;
  resp_type               r_b_resp;
  logic [31:0]            r_wr_addr;
  logic [AXIL_DATA_W-1:0] r_wr_data;
  logic [AXIL_STRB_W-1:0] r_wr_strb;

  rd_state_t              r_rd_state;
  logic                   r_ar_rdy, r_r_vld;
  logic [AXIL_DATA_W-1:0] r_r_data;
  resp_type               r_r_resp;

  logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_cm_hit, w_ar_hit;
  logic [31:0]            w_cm_addr;
  logic [AXIL_DATA_W-1:0] w_cm_data, w_mem_rdata;
  logic [AXIL_STRB_W-1:0] w_cm_strb;
  logic                   w_unused_lsbs;

  // BASE_ADDR is 4*DEPTH aligned, so a hit is simply a match on the bits above the word index.
  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:AW+2] == BASE_ADDR[31:AW+2];
  endfunction

  assign w_aw_hs   = s_wr_addr_valid & r_aw_rdy;
  assign w_w_hs    = s_wr_data_valid & r_w_rdy;
  assign w_ar_hs   = s_rd_addr_valid & r_ar_rdy;
  assign w_cm_addr = (r_wr_state == W_HAVE_ADDR) ? r_wr_addr : s_wr_addr;
  assign w_cm_data = (r_wr_state == W_HAVE_DATA) ? r_wr_data : s_wr_data;
  assign w_cm_strb = (r_wr_state == W_HAVE_DATA) ? r_wr_strb : s_wr_strb;
  assign w_commit  = ((r_wr_state == W_IDLE) && w_aw_hs && w_w_hs) ||
                     ((r_wr_state == W_HAVE_ADDR) && w_w_hs) ||
                     ((r_wr_state == W_HAVE_DATA) && w_aw_hs);
  assign w_cm_hit  = addr_hit(w_cm_addr);
  assign w_ar_hit  = addr_hit(s_rd_addr);
  assign w_unused_lsbs = ^{w_cm_addr[1:0], s_rd_addr[1:0]};

  axil_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_commit && w_cm_hit),
    .i_waddr (w_cm_addr[AW+1:2]),
    .i_wdata (w_cm_data),
    .i_wstrb (w_cm_strb),
    .i_raddr (s_rd_addr[AW+1:2]),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_state <= W_IDLE;
      r_aw_rdy   <= 1'b1;
      r_w_rdy    <= 1'b1;
      r_b_vld    <= 1'b0;
      r_b_resp   <= OKAY;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA: begin
          if (w_commit) begin
            r_wr_state <= W_RESP;
            r_aw_rdy   <= 1'b0;
            r_w_rdy    <= 1'b0;
            r_b_vld    <= 1'b1;
            r_b_resp   <= w_cm_hit ? OKAY : DECERR;
          end else if (w_aw_hs) begin
            r_wr_state <= W_HAVE_ADDR;
            r_wr_addr  <= s_wr_addr;
            r_aw_rdy   <= 1'b0;
          end else if (w_w_hs) begin
            r_wr_state <= W_HAVE_DATA;
            r_wr_data  <= s_wr_data;
            r_wr_strb  <= s_wr_strb;
            r_w_rdy    <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_wr_resp_ready) begin
            r_wr_state <= W_IDLE;
            r_aw_rdy   <= 1'b1;
            r_w_rdy    <= 1'b1;
            r_b_vld    <= 1'b0;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state <= R_IDLE;
      r_ar_rdy   <= 1'b1;
      r_r_vld    <= 1'b0;
      r_r_data   <= '0;
      r_r_resp   <= OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= R_DATA;
            r_ar_rdy   <= 1'b0;
            r_r_vld    <= 1'b1;
            r_r_data   <= w_ar_hit ? w_mem_rdata : '0;
            r_r_resp   <= w_ar_hit ? OKAY : DECERR;
          end
        end
        R_DATA: begin
          if (s_rd_ready) begin
            r_rd_state <= R_IDLE;
            r_ar_rdy   <= 1'b1;
            r_r_vld    <= 1'b0;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign s_wr_addr_ready = r_aw_rdy;
  assign s_wr_data_ready = r_w_rdy;
  assign s_wr_resp_valid = r_b_vld;
  assign s_wr_resp       = r_b_resp;
  assign s_rd_addr_ready = r_ar_rdy;
  assign s_rd_valid      = r_r_vld;
  assign s_rd_data       = r_r_data;
  assign s_rd_resp       = r_r_resp;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: vector table of write/read pairs with response scoreboards,
// plus hand-written back-pressure, same-edge write/read and mid-transaction reset sequences.
module tb_axi_lite_slave_mem;
  import dpi_config::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_wr_addr, s_wr_data, s_rd_addr, s_rd_data;
  logic [3:0]  s_wr_strb;
  logic        s_wr_addr_valid, s_wr_addr_ready, s_wr_data_valid, s_wr_data_ready;
  logic        s_wr_resp_valid, s_wr_resp_ready;
  logic        s_rd_addr_valid, s_rd_addr_ready, s_rd_valid, s_rd_ready;
  resp_type    s_wr_resp, s_rd_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    resp_type    r;
  } rexp_t;

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          gap;
    resp_type    wr;
    logic [31:0] ra;
    logic [31:0] rd;
    resp_type    rr;
  } vec_t;

  resp_type wq[$];
  rexp_t    rq[$];
  vec_t     vecs[9];

  always #5 clk = ~clk;

  axi_lite_slave_mem dut (
    .clk             (clk),
    .rst             (rst),
    .s_wr_addr       (s_wr_addr),
    .s_wr_addr_valid (s_wr_addr_valid),
    .s_wr_addr_ready (s_wr_addr_ready),
    .s_wr_data       (s_wr_data),
    .s_wr_strb       (s_wr_strb),
    .s_wr_data_valid (s_wr_data_valid),
    .s_wr_data_ready (s_wr_data_ready),
    .s_wr_resp       (s_wr_resp),
    .s_wr_resp_valid (s_wr_resp_valid),
    .s_wr_resp_ready (s_wr_resp_ready),
    .s_rd_addr       (s_rd_addr),
    .s_rd_addr_valid (s_rd_addr_valid),
    .s_rd_addr_ready (s_rd_addr_ready),
    .s_rd_data       (s_rd_data),
    .s_rd_resp       (s_rd_resp),
    .s_rd_valid      (s_rd_valid),
    .s_rd_ready      (s_rd_ready)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // gap = 0: both channels together; gap > 0: address first, data gap cycles later; gap < 0: data first.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int gap, input resp_type er);
    bit aw_done, w_done, aw_hs, w_hs;
    int lag;
    lag = (gap < 0) ? -gap : gap;
    wq.push_back(er);
    aw_done = 1'b0;
    w_done  = 1'b0;
    s_wr_addr = a;
    s_wr_data = d;
    s_wr_strb = s;
    s_wr_addr_valid = (gap >= 0);
    s_wr_data_valid = (gap <= 0);
    for (int t = 1; t <= 50 && !(aw_done && w_done); t++) begin
      aw_hs = s_wr_addr_valid && s_wr_addr_ready;
      w_hs  = s_wr_data_valid && s_wr_data_ready;
      @(posedge clk);
      @(negedge clk);
      if (aw_hs) begin aw_done = 1'b1; s_wr_addr_valid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_wr_data_valid = 1'b0; end
      if (t == lag) begin
        if (gap > 0) s_wr_data_valid = 1'b1;
        else         s_wr_addr_valid = 1'b1;
      end
    end
    s_wr_addr_valid = 1'b0;
    s_wr_data_valid = 1'b0;
    chk(aw_done && w_done && s_wr_resp_valid, "wr_handshake_latency",
        64'({aw_done, w_done, s_wr_resp_valid}), 64'h7);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input resp_type er);
    bit ok, hs;
    rexp_t e;
    e.d = ed;
    e.r = er;
    rq.push_back(e);
    ok = 1'b0;
    s_rd_addr = a;
    s_rd_addr_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      hs = s_rd_addr_ready;
      @(posedge clk);
      @(negedge clk);
      ok = hs;
    end
    s_rd_addr_valid = 1'b0;
    chk(ok && s_rd_valid, "rd_handshake_latency", 64'({ok, s_rd_valid}), 64'h3);
  endtask

  always @(negedge clk) begin : wr_mon
    resp_type e;
    if (rst && s_wr_resp_valid && s_wr_resp_ready) begin
      if (wq.size() == 0) chk(1'b0, "wr_resp_unexpected", 64'(s_wr_resp), 64'h0);
      else begin
        e = wq.pop_front();
        chk(s_wr_resp == e, "wr_resp", 64'(s_wr_resp), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : rd_mon
    rexp_t e;
    if (rst && s_rd_valid && s_rd_ready) begin
      if (rq.size() == 0) chk(1'b0, "rd_unexpected", 64'(s_rd_data), 64'h0);
      else begin
        e = rq.pop_front();
        chk(s_rd_data == e.d && s_rd_resp == e.r, "rd_data_resp",
            {30'h0, s_rd_resp, s_rd_data}, {30'h0, e.r, e.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0102_0304, 4'hF,  0, OKAY,   32'h0000_0000, 32'h0102_0304, OKAY};
    vecs[1] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF,  0, OKAY,   32'h0000_0010, 32'hDEAD_BEEF, OKAY};
    vecs[2] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'hF,  1, OKAY,   32'h0000_0020, 32'hFFFF_FFFF, OKAY};
    vecs[3] = '{32'h0000_0020, 32'h1122_3344, 4'h5,  3, OKAY,   32'h0000_0020, 32'hFF22_FF44, OKAY};
    vecs[4] = '{32'h0000_0400, 32'h1234_5678, 4'hF,  0, DECERR, 32'h0000_0000, 32'h0102_0304, OKAY};
    vecs[5] = '{32'h0000_03FC, 32'hCAFE_F00D, 4'hF, -2, OKAY,   32'h0000_03FC, 32'hCAFE_F00D, OKAY};
    vecs[6] = '{32'h0000_0013, 32'h0000_0000, 4'h0,  0, OKAY,   32'h0000_0011, 32'hDEAD_BEEF, OKAY};
    vecs[7] = '{32'h0000_0022, 32'h0000_0000, 4'hA, -1, OKAY,   32'h0000_0020, 32'h0022_0044, OKAY};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'hF,  0, DECERR, 32'h0000_0400, 32'h0000_0000, DECERR};

    rst = 1'b0;
    s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0; s_rd_addr = '0;
    s_wr_addr_valid = 1'b0; s_wr_data_valid = 1'b0; s_rd_addr_valid = 1'b0;
    s_wr_resp_ready = 1'b1; s_rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk(s_wr_addr_ready && s_wr_data_ready && s_rd_addr_ready, "reset_readies",
        64'({s_wr_addr_ready, s_wr_data_ready, s_rd_addr_ready}), 64'h7);
    chk(!s_wr_resp_valid && !s_rd_valid, "reset_valids", 64'({s_wr_resp_valid, s_rd_valid}), 64'h0);
    chk(s_wr_resp == OKAY && s_rd_resp == OKAY && s_rd_data == 32'h0, "reset_payload",
        {28'h0, s_wr_resp, s_rd_resp, s_rd_data}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].gap, vecs[i].wr);
      rd(vecs[i].ra, vecs[i].rd, vecs[i].rr);
    end

    // Responses held under back-pressure for 5 cycles, then released.
    @(posedge clk); #1;
    s_wr_resp_ready = 1'b0;
    s_rd_ready = 1'b0;
    @(negedge clk);
    wr(32'h0000_0034, 32'h55AA_55AA, 4'hF, 0, OKAY);
    rd(32'h0000_0010, 32'hDEAD_BEEF, OKAY);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk(s_wr_resp_valid && s_wr_resp == OKAY && s_rd_valid && s_rd_data == 32'hDEAD_BEEF &&
          s_rd_resp == OKAY && !s_wr_addr_ready && !s_wr_data_ready && !s_rd_addr_ready,
          "backpressure_hold",
          {25'h0, s_wr_resp_valid, s_rd_valid, s_wr_addr_ready, s_wr_data_ready, s_rd_addr_ready,
           s_rd_resp, s_rd_data}, {25'h0, 5'b11000, 2'b00, 32'hDEAD_BEEF});
    end
    @(posedge clk); #1;
    s_wr_resp_ready = 1'b1;
    s_rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(!s_wr_resp_valid && !s_rd_valid && s_wr_addr_ready && s_wr_data_ready && s_rd_addr_ready &&
        wq.size() == 0 && rq.size() == 0, "backpressure_release",
        64'({s_wr_resp_valid, s_rd_valid, s_wr_addr_ready, s_wr_data_ready, s_rd_addr_ready}), 64'h7);

    // Same-edge write commit and read accept to one word.
    fork
      wr(32'h0000_0008, 32'hA5A5_A5A5, 4'hF, 0, OKAY);
      rd(32'h0000_0008, 32'hA5A5_A5A5, OKAY);
    join
    @(negedge clk);

    // Reset while the write holds only an address and the read response is stalled.
    s_rd_ready = 1'b0;
    s_wr_addr = 32'h0000_0010;
    s_wr_data = 32'h0BAD_BAD0;
    s_wr_strb = 4'hF;
    s_wr_addr_valid = 1'b1;
    s_rd_addr = 32'h0000_0000;
    s_rd_addr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_wr_addr_valid = 1'b0;
    s_rd_addr_valid = 1'b0;
    chk(!s_wr_addr_ready && s_wr_data_ready && s_rd_valid, "pre_reset_state",
        64'({s_wr_addr_ready, s_wr_data_ready, s_rd_valid}), 64'h3);
    #2 rst = 1'b0;
    #1;
    chk(s_wr_addr_ready && s_wr_data_ready && s_rd_addr_ready && !s_wr_resp_valid && !s_rd_valid &&
        s_rd_data == 32'h0 && s_rd_resp == OKAY && s_wr_resp == OKAY, "mid_reset_outputs",
        {25'h0, s_wr_addr_ready, s_wr_data_ready, s_rd_addr_ready, s_wr_resp_valid, s_rd_valid,
         s_rd_resp, s_rd_data}, {25'h0, 5'b11100, 2'b00, 32'h0});
    s_rd_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr(32'h0000_0030, 32'h0BAD_BAD0, 4'hF, -1, OKAY);
    rd(32'h0000_0010, 32'hDEAD_BEEF, OKAY);
    rd(32'h0000_0030, 32'h0BAD_BAD0, OKAY);
    rd(32'h0000_0000, 32'h0102_0304, OKAY);
    @(negedge clk);
    @(negedge clk);
    chk(wq.size() == 0 && rq.size() == 0, "scoreboard_drained",
        64'({wq.size(), rq.size()}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
